rr_arbiter8: RTL

Eight-way round-robin arbiter with a bounded hold time. It shares one instance of a combinational resource (the 4-to-1 mux, full adder or priority-encoder datapath) between up to eight requesters. Each cycle it decides which requester owns the resource and drives a registered one-hot grant plus an encoded index, which steers the resource's input select logic. It sits between the requester ports and the shared datapath and is the only sequential element on that path.

---
 rtl/rr_arbiter8.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-way round-robin arbiter with bounded hold time.
//
// Shares one combinational resource between up to eight requesters. The
// grant is registered, so there is no combinational path from REQ to any
// output. A grantee keeps the resource while it holds REQ high. If another
// requester is waiting, the grantee is preempted after MAX_HOLD cycles.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles under contention (1..15)
// Ports:
//   CLK      in   1  clock, rising edge
//   RST      in   1  synchronous reset, active high
//   REQ      in   8  request vector, one bit per requester
//   GNT      out  8  registered one-hot grant, zero when idle
//   GNT_IDX  out  3  registered index of the grantee, zero when idle
//   GNT_VLD  out  1  registered OR of GNT
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] GNT_IDX,
  output logic       GNT_VLD
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [2:0] last_reg, last_next;
  logic [3:0] hcnt_reg, hcnt_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] idx_reg, idx_next;
  logic       vld_reg, vld_next;

  // Requests rotated so that bit j holds requester (last_reg + j + 1) mod 8.
  // The lowest set bit is therefore the first hit in round-robin order.
  // The current grantee sits at bit 7, so it is searched last.
  logic [7:0] rot_req;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic [7:0] others;
  logic       grant_new;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = REQ[3'(last_reg + 3'(gi + 1))];
    end
  endgenerate

  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) win_off = 3'(i);
    end
  end

  assign win_idx = last_reg + win_off + 3'd1;

  // In BUSY, last_reg is the current grantee.
  assign others = REQ & ~(8'd1 << last_reg);

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    hcnt_next  = hcnt_reg;
    grant_new  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|REQ) grant_new = 1'b1;
      end
      BUSY: begin
        if (!REQ[last_reg]) begin
          // Release takes priority over hold expiry. Hand off with no bubble.
          if (|others) grant_new = 1'b1;
          else         state_next = IDLE;
        end else if ((|others) && (hcnt_reg == HOLD_LAST)) begin
          grant_new = 1'b1;
        end else if (hcnt_reg != HOLD_LAST) begin
          hcnt_next = hcnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (grant_new) begin
      state_next = BUSY;
      last_next  = win_idx;
      hcnt_next  = 4'd0;
    end

    gnt_next = (state_next == BUSY) ? (8'd1 << last_next) : 8'd0;
    idx_next = (state_next == BUSY) ? last_next : 3'd0;
    vld_next = (state_next == BUSY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      last_reg  <= 3'd7;
      hcnt_reg  <= 4'd0;
      gnt_reg   <= 8'd0;
      idx_reg   <= 3'd0;
      vld_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      hcnt_reg  <= hcnt_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      vld_reg   <= vld_next;
    end
  end

  assign GNT     = gnt_reg;
  assign GNT_IDX = idx_reg;
  assign GNT_VLD = vld_reg;

endmodule
